seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Display back-end that sits directly downstream of the display clock divider.
- Converts a 14-bit binary value to four BCD digits with an iterative double-dabble FSM.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display, advancing one digit per rising edge of the divider output.
- Runs entirely in the clk_in domain. The divider output is sampled as data; it is never used as a clock.

Parameters:
- VALUE_W, 14, width of value_in; max displayable value 9999.
- BLANK_LZ, 1, 1 = leading-zero blanking enabled; 0 = all four digits always shown.

Ports:
- clk_in  input  1  system clock; the same clock that drives the divider.
- rst_n  input  1  asynchronous active-low reset.
- scan_clk  input  1  divided_clk from the display clock divider; a registered level in the clk_in domain.
- value_in  input  14  binary value to display.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit enables, active-low, one-hot; an[0] = rightmost (units) digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst_n low, asynchronous), all registers cleared:
  - an=4'b1111, seg=7'b1111111, busy=0.
  - Digit index=0, scan_clk history=0.
  - Captured value=0, display digits=0,0,0,0, overflow flag=0, FSM=IDLE.
- Edge detect: scan_clk is registered every clk_in cycle. scan_tick = scan_clk & ~scan_clk_q, i.e. one cycle per rising edge. Falling edges are ignored.
- Conversion FSM states IDLE, LOAD, SHIFT, DONE:
  - IDLE: if value_in != captured value, go to LOAD and capture value_in. Otherwise stay in IDLE.
  - LOAD: clear the 16-bit BCD shift register, load the binary shift register, set shift count to 0, go to SHIFT. busy=1 from LOAD through DONE.
  - SHIFT: each cycle, first add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. After 14 shifts, go to DONE.
  - DONE: write the BCD result into the display digit registers atomically. Overflow flag = (captured value > 9999). Go to IDLE; busy drops the next cycle.
- Conversion latency: value_in change sampled at edge N; display digits update at edge N+16; busy is high for edges N+1..N+16.
- value_in changing during a conversion is ignored until IDLE. The comparison is then redone, so the final value always wins.
- Scan:
  - On scan_tick, the digit index advances 0->1->2->3->0 (wraps).
  - an and seg are registered: both reflect the new index one cycle after scan_tick.
  - Between ticks, an and seg hold, but seg tracks the display registers if they change (no torn digits within one DONE).
- Decode (active-low), 0..9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blanking (BLANK_LZ=1):
  - Digit k (k=3..1) shows 1111111 if it and all higher digits are 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The an bit for a blanked digit is still driven low; only the segments are off.
- Overflow: when the overflow flag is set, all four digits show dash 0111111. Blanking does not apply.
- Simultaneous DONE and scan_tick: the digit shown after the tick uses the new display registers.
- First scan_tick after reset selects index 1. Before any tick, an stays 1111.

Test Plan:
- Reset, hold value_in=0, drive scan_clk with period 8 cycles -> busy never rises. After 4 ticks, an has cycled through 1101,1011,0111,1110. seg=1000000 on digit 0 and 1111111 on digits 1–3.
- value_in=1234 at cycle 10 -> busy=1 cycles 11–26. Afterwards digits 3..0 show seg 1111001, 0100100, 0110000, 0011001.
- value_in=0705, BLANK_LZ=1 -> digit 3 blank; digits 2..0 show 1111000, 1000000, 0010010. The interior zero is not blanked.
- value_in=12000 -> all four digits 0111111. Then value_in=9999 -> all four digits 0010000.
- value_in changed 42 -> 58 on the third SHIFT cycle -> display first shows 42, then busy re-asserts within 1 cycle of IDLE, and the display ends at 58.
- rst_n low mid-SHIFT and mid-scan -> an=1111, seg=1111111, busy=0 immediately (asynchronous). After release, the current value_in is reconverted and the scan restarts from index 0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Binary-to-BCD conversion (iterative double-dabble) feeding a 4-digit
// common-anode seven-segment scanner advanced by rising edges of scan_clk.
module seven_seg_scanner #(
  parameter int unsigned VALUE_W  = 14,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               scan_clk,
  input  logic [VALUE_W-1:0] value_in,
  output logic               busy,
  output logic [3:0]         an,
  output logic [6:0]         seg
);

  localparam int unsigned CNT_W = $clog2(VALUE_W);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VALUE_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state;
  logic [VALUE_W-1:0] cap;
  logic [15:0]        bcd;
  logic [15:0]        bcd_adj;
  logic [VALUE_W-1:0] bin;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        digits;
  logic               ovf;
  logic               ovf_calc;
  logic [15:0]        digits_nx;
  logic               ovf_nx;

  logic               scan_q;
  logic               scan_tick;
  logic [1:0]         idx;
  logic [1:0]         idx_sel;
  logic [3:0]         dig;
  logic               blank;
  logic [6:0]         seg_nx;

  assign busy      = (state != IDLE);
  assign scan_tick = scan_clk & ~scan_q;
  assign ovf_calc  = (32'(cap) > 32'd9999);

  // Display registers as they will be after this edge, so the scanner never
  // shows a stale digit when DONE and a scan tick coincide.
  assign digits_nx = (state == DONE) ? bcd      : digits;
  assign ovf_nx    = (state == DONE) ? ovf_calc : ovf;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cap    <= '0;
      bcd    <= '0;
      bin    <= '0;
      cnt    <= '0;
      digits <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value_in != cap) begin
            cap   <= value_in;
            state <= LOAD;
          end
        end
        LOAD: begin
          bcd   <= '0;
          bin   <= cap;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd <= {bcd_adj[14:0], bin[VALUE_W-1]};
          bin <= {bin[VALUE_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_SHIFT) state <= DONE;
        end
        DONE: begin
          digits <= bcd;
          ovf    <= ovf_calc;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    idx_sel = scan_tick ? idx + 2'd1 : idx;
    dig     = digits_nx[{idx_sel, 2'b00} +: 4];
    case (idx_sel)
      2'd3:    blank = (digits_nx[15:12] == 4'd0);
      2'd2:    blank = (digits_nx[15:8]  == 8'd0);
      2'd1:    blank = (digits_nx[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    blank = blank & BLANK_LZ;
    if (ovf_nx) begin
      seg_nx = 7'b0111111;
    end else if (blank) begin
      seg_nx = '1;
    end else begin
      case (dig)
        4'd0:    seg_nx = 7'b1000000;
        4'd1:    seg_nx = 7'b1111001;
        4'd2:    seg_nx = 7'b0100100;
        4'd3:    seg_nx = 7'b0110000;
        4'd4:    seg_nx = 7'b0011001;
        4'd5:    seg_nx = 7'b0010010;
        4'd6:    seg_nx = 7'b0000010;
        4'd7:    seg_nx = 7'b1111000;
        4'd8:    seg_nx = 7'b0000000;
        4'd9:    seg_nx = 7'b0010000;
        default: seg_nx = '1;
      endcase
    end
  end

  // Scanner stays dark (an = 1111) until the first tick after reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= 1'b0;
      idx    <= '0;
      an     <= '1;
      seg    <= '1;
    end else begin
      scan_q <= scan_clk;
      if (scan_tick) begin
        idx <= idx_sel;
        an  <= ~(4'b0001 << idx_sel);
        seg <= seg_nx;
      end else if (an != 4'b1111) begin
        seg <= seg_nx;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic [13:0] value_in;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int tests  = 0;
  int failed = 0;

  int mdl_value = 0;
  int mdl_idx   = 0;
  logic [10:0] sb[$];

  seven_seg_scanner #(.VALUE_W(14), .BLANK_LZ(1'b1)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .scan_clk (scan_clk),
    .value_in (value_in),
    .busy     (busy),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p;
    int d;
    if (v > 9999) return 7'b0111111;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    if (k != 0 && v < p) return 7'b1111111;
    d = (v / p) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One scan_clk period (8 cycles); expectation queued as the edge is driven.
  task automatic scan_drive();
    logic [3:0] ea;
    mdl_idx = (mdl_idx + 1) % 4;
    ea = ~(4'b0001 << mdl_idx);
    sb.push_back({ea, exp_seg(mdl_value, mdl_idx)});
    scan_clk = 1'b1;
    tick(4);
    scan_clk = 1'b0;
    tick(4);
  endtask

  task automatic wait_busy_low(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 64) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic set_value(input int v, output int cycles);
    value_in = 14'(v);
    tick(1);
    tests++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL busy_rise v=%0d: busy=%b want 1", v, busy);
    end
    wait_busy_low(cycles);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_clk = 1'b0; value_in = '0;
    tick(3);
    tests++;
    if ({an, seg, busy} !== {4'b1111, 7'b1111111, 1'b0}) begin
      failed++;
      $display("FAIL reset_hold: an=%b seg=%b busy=%b want 1111 1111111 0", an, seg, busy);
    end
    rst_n = 1'b1;
    tick(3);
    tests++;
    if ({an, seg, busy} !== {4'b1111, 7'b1111111, 1'b0}) begin
      failed++;
      $display("FAIL reset_release: an=%b seg=%b busy=%b want 1111 1111111 0", an, seg, busy);
    end
  endtask

  task automatic test_zero_scan();
    logic [10:0] e;
    mdl_value = 0;
    for (int i = 0; i < 4; i++) begin
      scan_drive();
      e = sb.pop_front();
      tests++;
      if ({an, seg} !== e) begin
        failed++;
        $display("FAIL zero_scan[%0d]: an=%b seg=%b want %b %b", i, an, seg, e[10:7], e[6:0]);
      end
      tests++;
      if (busy !== 1'b0) begin
        failed++;
        $display("FAIL zero_busy[%0d]: busy=%b want 0", i, busy);
      end
    end
  endtask

  task automatic test_convert();
    int c;
    logic [10:0] e;
    set_value(1234, c);
    mdl_value = 1234;
    tests++;
    if (c !== 16) begin
      failed++;
      $display("FAIL conv_latency: busy cycles=%0d want 16", c);
    end
    tests++;
    if (seg !== exp_seg(1234, mdl_idx)) begin
      failed++;
      $display("FAIL conv_update: seg=%b want %b", seg, exp_seg(1234, mdl_idx));
    end
    for (int i = 0; i < 4; i++) begin
      scan_drive();
      e = sb.pop_front();
      tests++;
      if ({an, seg} !== e) begin
        failed++;
        $display("FAIL conv_scan[%0d]: an=%b seg=%b want %b %b", i, an, seg, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_interior_zero();
    int c;
    logic [10:0] e;
    set_value(705, c);
    mdl_value = 705;
    tests++;
    if (c !== 16) begin
      failed++;
      $display("FAIL iz_latency: busy cycles=%0d want 16", c);
    end
    for (int i = 0; i < 4; i++) begin
      scan_drive();
      e = sb.pop_front();
      tests++;
      if ({an, seg} !== e) begin
        failed++;
        $display("FAIL iz_scan[%0d]: an=%b seg=%b want %b %b", i, an, seg, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_overflow();
    int c;
    logic [10:0] e;
    int vals[2] = '{12000, 9999};
    for (int j = 0; j < 2; j++) begin
      set_value(vals[j], c);
      mdl_value = vals[j];
      tests++;
      if (c !== 16) begin
        failed++;
        $display("FAIL ovf_latency v=%0d: busy cycles=%0d want 16", vals[j], c);
      end
      for (int i = 0; i < 4; i++) begin
        scan_drive();
        e = sb.pop_front();
        tests++;
        if ({an, seg} !== e) begin
          failed++;
          $display("FAIL ovf_scan v=%0d [%0d]: an=%b seg=%b want %b %b",
                   vals[j], i, an, seg, e[10:7], e[6:0]);
        end
      end
    end
  endtask

  task automatic test_race();
    int c;
    logic [10:0] e;
    value_in = 14'd42;
    tick(1);
    tick(3);
    value_in = 14'd58;
    wait_busy_low(c);
    tests++;
    if (busy !== 1'b0 || seg !== exp_seg(42, mdl_idx)) begin
      failed++;
      $display("FAIL race_first: busy=%b seg=%b want 0 %b", busy, seg, exp_seg(42, mdl_idx));
    end
    tick(1);
    tests++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL race_rebusy: busy=%b want 1", busy);
    end
    wait_busy_low(c);
    tests++;
    if (c !== 16) begin
      failed++;
      $display("FAIL race_latency: busy cycles=%0d want 16", c);
    end
    mdl_value = 58;
    for (int i = 0; i < 4; i++) begin
      scan_drive();
      e = sb.pop_front();
      tests++;
      if ({an, seg} !== e) begin
        failed++;
        $display("FAIL race_scan[%0d]: an=%b seg=%b want %b %b", i, an, seg, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    value_in = 14'd3;
    tick(16);
    mdl_value = 3;
    scan_drive();
    e = sb.pop_front();
    tests++;
    if ({an, seg} !== e) begin
      failed++;
      $display("FAIL done_tick: an=%b seg=%b want %b %b", an, seg, e[10:7], e[6:0]);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [10:0] e;
    scan_drive();
    void'(sb.pop_front());
    value_in = 14'd321;
    tick(5);
    scan_clk = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #2;
    tests++;
    if ({an, seg, busy} !== {4'b1111, 7'b1111111, 1'b0}) begin
      failed++;
      $display("FAIL reset_async: an=%b seg=%b busy=%b want 1111 1111111 0", an, seg, busy);
    end
    scan_clk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    mdl_idx = 0;
    tick(1);
    tests++;
    if (busy !== 1'b1 || an !== 4'b1111) begin
      failed++;
      $display("FAIL reset_reconv: busy=%b an=%b want 1 1111", busy, an);
    end
    wait_busy_low(c);
    tests++;
    if (c !== 16) begin
      failed++;
      $display("FAIL reset_latency: busy cycles=%0d want 16", c);
    end
    mdl_value = 321;
    for (int i = 0; i < 4; i++) begin
      scan_drive();
      e = sb.pop_front();
      tests++;
      if ({an, seg} !== e) begin
        failed++;
        $display("FAIL reset_scan[%0d]: an=%b seg=%b want %b %b", i, an, seg, e[10:7], e[6:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_scan();
    test_convert();
    test_interior_zero();
    test_overflow();
    test_race();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
